comp2_serial: RTL

//  Multi-cycle two's-complement unit: negate, absolute value, saturating negate or pass-through
//  of a WIDTH-bit signed operand. Works DIGIT bits per cycle, LSB first, with a carry register.

---
 rtl/comp2_serial.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/comp2_serial.sv
// comp2_serial: multi-cycle two's-complement unit (pass, negate, abs, saturating negate).
// The operand is consumed DIGIT bits per cycle, LSB first, through a single digit-wide
// adder with a carry register. The visible result M only changes on the DONE edge.
//
// Handshake: a request is accepted on any rising edge where start=1 and the unit is
// in IDLE or DONE; busy=1 while digits are processed; done is a one-cycle pulse marking
// m/ovf as newly valid; start while busy=1 is dropped, never queued.
module comp2_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] m,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SAT_VAL  = ~MIN_VAL;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic             accept;
    logic             last_digit;

    // Latched operation context
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] res_sh;
    logic             inv_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             ovf_pend;
    logic             sat_pend;

    // Request decode
    logic             inv_in;
    logic             a_is_min;
    logic             ovf_in;
    logic             sat_in;

    // Digit datapath
    logic [DIGIT-1:0] digit_x;
    logic [DIGIT:0]   sum;
    logic [WIDTH-1:0] res_next;

    assign state_dbg  = state;
    assign last_digit = (cnt == LAST_CNT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and handshake outputs; DONE accepts a new request back-to-back
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = S_BUSY;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Mode decode: the carry-in always equals the inversion flag, so one bit covers both
    always_comb begin
        inv_in = 1'b0;
        case (mode)
            2'b00:   inv_in = 1'b0;
            2'b01:   inv_in = 1'b1;
            2'b11:   inv_in = 1'b1;
            default: inv_in = a[WIDTH-1];
        endcase
        a_is_min = (a == MIN_VAL);
        ovf_in   = a_is_min && (mode != 2'b00);
        sat_in   = a_is_min && (mode == 2'b11);
    end

    // One digit of (a ^ inv) + carry; the new digit enters the result from the top
    always_comb begin
        digit_x  = a_sh[DIGIT-1:0] ^ {DIGIT{inv_q}};
        sum      = {1'b0, digit_x} + {{DIGIT{1'b0}}, carry_q};
        res_next = WIDTH'({sum[DIGIT-1:0], res_sh} >> DIGIT);
    end

    // Datapath: latch on accept, shift per digit, publish m/ovf on the final digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            res_sh   <= '0;
            inv_q    <= 1'b0;
            carry_q  <= 1'b0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            sat_pend <= 1'b0;
            m        <= '0;
            ovf      <= 1'b0;
        end else if (accept) begin
            a_sh     <= a;
            res_sh   <= '0;
            inv_q    <= inv_in;
            carry_q  <= inv_in;
            cnt      <= '0;
            ovf_pend <= ovf_in;
            sat_pend <= sat_in;
        end else if (state == S_BUSY) begin
            a_sh    <= a_sh >> DIGIT;
            res_sh  <= res_next;
            carry_q <= sum[DIGIT];
            cnt     <= cnt + CNT_W'(1);
            if (last_digit) begin
                m   <= sat_pend ? SAT_VAL : res_next;
                ovf <= ovf_pend;
            end
        end
    end

endmodule
